button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/pop_pkg.sv | 37 +++
 rtl/button_conditioner_if.sv | 13 +
 rtl/button_channel.sv | 123 ++++++++++++
 rtl/button_conditioner.sv | 71 +++++++
 tb/tb_button_conditioner.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/pop_pkg.sv
// Shared constants for the front-panel button conditioner: button indices,
// the +/- pair table, the per-button state encoding and a counter-width helper.
package pop_pkg;

    localparam int NUM_BTN           = 6;
    localparam int BTN_MODE          = 0;
    localparam int BTN_LOAD_DEFAULTS = 1;
    localparam int BTN_PIE_PLUS      = 2;
    localparam int BTN_ST_PLUS       = 3;
    localparam int BTN_PIE_MINUS     = 4;
    localparam int BTN_ST_MINUS      = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SLOW = 2'd2,
        ST_FAST = 2'd3
    } btn_state_t;

    // Opposing +/- buttons; pressing both at once must not step either value.
    function automatic int pair_partner(input int idx);
        int partner;
        case (idx)
            BTN_PIE_PLUS:  partner = BTN_PIE_MINUS;
            BTN_PIE_MINUS: partner = BTN_PIE_PLUS;
            BTN_ST_PLUS:   partner = BTN_ST_MINUS;
            BTN_ST_MINUS:  partner = BTN_ST_PLUS;
            default:       partner = -1;
        endcase
        return partner;
    endfunction

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw panel inputs and the conditioned outputs.
interface button_conditioner_if;
    import pop_pkg::*;

    logic [NUM_BTN-1:0] btn_raw_n;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_pulse;
    logic               tick;

    modport master (output btn_raw_n, input btn_level, btn_pulse, tick);
    modport slave  (input btn_raw_n, output btn_level, btn_pulse, tick);

endinterface

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, tick-sampled debounce and the
// press / hold / slow-repeat / fast-repeat state machine.
module button_channel
    import pop_pkg::*;
#(
    parameter int DEB_TICKS    = 100,
    parameter int REPEAT_DELAY = 5000,
    parameter int REPEAT_SLOW  = 1000,
    parameter int FAST_AFTER   = 20000,
    parameter int REPEAT_FAST  = 200,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic clk_2M5,
    input  logic reset_n,
    input  logic raw_n,
    input  logic tick,
    input  logic mute,
    output logic level,
    output logic level_next,
    output logic pulse
);
    localparam int DEB_W  = cnt_width(DEB_TICKS - 1);
    localparam int HOLD_W = cnt_width(FAST_AFTER);
    localparam int PER_W  = cnt_width((REPEAT_SLOW > REPEAT_FAST) ? REPEAT_SLOW : REPEAT_FAST);

    localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEB_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_DELAY = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = HOLD_W'(FAST_AFTER);
    localparam logic [PER_W-1:0]  PER_SLOW   = PER_W'(REPEAT_SLOW);
    localparam logic [PER_W-1:0]  PER_FAST   = PER_W'(REPEAT_FAST);

    logic              sync1_reg, sync2_reg;
    logic              level_reg, pulse_reg;
    logic [DEB_W-1:0]  deb_reg, deb_next;
    logic [HOLD_W-1:0] hold_reg, hold_inc;
    logic [PER_W-1:0]  per_reg, per_inc;
    btn_state_t        state_reg;

    // level_next is exported so the top can judge pair conflicts in the same cycle.
    always_comb begin
        level_next = level_reg;
        deb_next   = deb_reg;
        if (tick) begin
            if (sync2_reg == level_reg) begin
                deb_next = '0;
            end else if (deb_reg == DEB_LAST) begin
                deb_next   = '0;
                level_next = sync2_reg;
            end else begin
                deb_next = deb_reg + DEB_W'(1);
            end
        end
    end

    assign hold_inc = (hold_reg == HOLD_SAT) ? hold_reg : hold_reg + HOLD_W'(1);
    assign per_inc  = per_reg + PER_W'(1);

    always_ff @(posedge clk_2M5) begin
        if (!reset_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            deb_reg   <= '0;
            level_reg <= 1'b0;
            pulse_reg <= 1'b0;
            hold_reg  <= '0;
            per_reg   <= '0;
            state_reg <= ST_IDLE;
        end else begin
            // Inverted on capture so a cleared synchroniser reads as released.
            sync1_reg <= ~raw_n;
            sync2_reg <= sync1_reg;
            deb_reg   <= deb_next;
            level_reg <= level_next;
            pulse_reg <= 1'b0;
            if (level_reg && !level_next) begin
                state_reg <= ST_IDLE;
            end else if (!level_reg && level_next) begin
                state_reg <= ST_HOLD;
                hold_reg  <= '0;
                per_reg   <= '0;
                pulse_reg <= !mute;
            end else if (tick) begin
                case (state_reg)
                    ST_HOLD: begin
                        hold_reg <= hold_inc;
                        if (REPEAT_EN && hold_inc == HOLD_DELAY) begin
                            state_reg <= ST_SLOW;
                            per_reg   <= '0;
                            pulse_reg <= !mute;
                        end
                    end
                    ST_SLOW: begin
                        hold_reg <= hold_inc;
                        if (per_inc == PER_SLOW) begin
                            per_reg   <= '0;
                            pulse_reg <= !mute;
                        end else begin
                            per_reg <= per_inc;
                        end
                        if (hold_inc == HOLD_SAT) begin
                            state_reg <= ST_FAST;
                            per_reg   <= '0;
                        end
                    end
                    ST_FAST: begin
                        hold_reg <= hold_inc;
                        if (per_inc == PER_FAST) begin
                            per_reg   <= '0;
                            pulse_reg <= !mute;
                        end else begin
                            per_reg <= per_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign level = level_reg;
    assign pulse = pulse_reg;

endmodule

// File: rtl/button_conditioner.sv
// Six-button front-panel conditioner: shared sample prescaler, one
// button_channel per button and +/- pair conflict suppression.
module button_conditioner
    import pop_pkg::*;
#(
    parameter int                 PRESCALE     = 256,
    parameter int                 DEB_TICKS    = 100,
    parameter int                 REPEAT_DELAY = 5000,
    parameter int                 REPEAT_SLOW  = 1000,
    parameter int                 FAST_AFTER   = 20000,
    parameter int                 REPEAT_FAST  = 200,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK  = 6'b111100
) (
    input  logic          clk_2M5,
    input  logic          reset_n,
    button_conditioner_if.slave bus
);
    localparam int                PRE_W    = cnt_width(PRESCALE - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]   pre_cnt_reg;
    logic               tick_reg;
    logic [NUM_BTN-1:0] chan_level, chan_level_next, chan_pulse, pair_mute;

    always_ff @(posedge clk_2M5) begin
        if (!reset_n) begin
            pre_cnt_reg <= '0;
            tick_reg    <= 1'b0;
        end else if (pre_cnt_reg == PRE_LAST) begin
            pre_cnt_reg <= '0;
            tick_reg    <= 1'b1;
        end else begin
            pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
            tick_reg    <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
        localparam int PARTNER = pair_partner(gi);

        // Mute judged on next-cycle levels so the registered pulse never leaks.
        if (PARTNER >= 0) begin : g_pair
            assign pair_mute[gi] = chan_level_next[gi] & chan_level_next[PARTNER];
        end else begin : g_solo
            assign pair_mute[gi] = 1'b0;
        end

        button_channel #(
            .DEB_TICKS    (DEB_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_SLOW  (REPEAT_SLOW),
            .FAST_AFTER   (FAST_AFTER),
            .REPEAT_FAST  (REPEAT_FAST),
            .REPEAT_EN    (REPEAT_MASK[gi])
        ) u_chan (
            .clk_2M5    (clk_2M5),
            .reset_n    (reset_n),
            .raw_n      (bus.btn_raw_n[gi]),
            .tick       (tick_reg),
            .mute       (pair_mute[gi]),
            .level      (chan_level[gi]),
            .level_next (chan_level_next[gi]),
            .pulse      (chan_pulse[gi])
        );
    end

    assign bus.btn_level = chan_level;
    assign bus.btn_pulse = chan_pulse;
    assign bus.tick      = tick_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed segment table, a reset-during-repeat
// sequence and random presses, all checked cycle by cycle against a sample-level model.
`timescale 1ns/1ps
module tb_button_conditioner;
    import pop_pkg::*;

    localparam int         PRESCALE     = 4;
    localparam int         DEB_TICKS    = 3;
    localparam int         REPEAT_DELAY = 10;
    localparam int         REPEAT_SLOW  = 4;
    localparam int         FAST_AFTER   = 30;
    localparam int         REPEAT_FAST  = 2;
    localparam logic [5:0] REPEAT_MASK  = 6'b111100;

    typedef struct {
        logic [5:0] raw_n;
        int         n_ticks;
        logic [5:0] exp_level;
        int         exp_pulses;
    } seg_t;

    logic clk_2M5 = 1'b0;
    logic reset_n = 1'b0;

    button_conditioner_if bus();

    button_conditioner #(
        .PRESCALE     (PRESCALE),
        .DEB_TICKS    (DEB_TICKS),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_SLOW  (REPEAT_SLOW),
        .FAST_AFTER   (FAST_AFTER),
        .REPEAT_FAST  (REPEAT_FAST),
        .REPEAT_MASK  (REPEAT_MASK)
    ) dut (
        .clk_2M5 (clk_2M5),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #200 clk_2M5 = ~clk_2M5;

    int         n_vec = 0;
    int         n_err = 0;
    int         tick_no = 0;
    int         seg_pulses = 0;
    logic [5:0] m_level;
    int         m_hold [6];
    logic [5:0] m_hist [$];
    seg_t       table_v [11];

    task automatic check(input string what, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at tick %0d: got 0x%0h, required 0x%0h", what, tick_no, got, want);
        end
    endtask

    // Repeat schedule by hold time (ticks since the accepted press).
    function automatic bit repeat_due(input int h);
        if (h == REPEAT_DELAY) return 1'b1;
        if (h > REPEAT_DELAY && h <= FAST_AFTER) return ((h - REPEAT_DELAY) % REPEAT_SLOW) == 0;
        if (h > FAST_AFTER) return ((h - FAST_AFTER) % REPEAT_FAST) == 0;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_level = '0;
        m_hist.delete();
        for (int i = 0; i < DEB_TICKS; i++) m_hist.push_back(6'b000000);
        for (int b = 0; b < 6; b++) m_hold[b] = 0;
    endtask

    // A level flips once the last DEB_TICKS samples all disagree with it.
    task automatic model_sample(input logic [5:0] pressed, output logic [5:0] pulse);
        logic [5:0] new_level;
        bit         flip;
        m_hist.push_back(pressed);
        void'(m_hist.pop_front());
        new_level = m_level;
        pulse     = '0;
        for (int b = 0; b < 6; b++) begin
            flip = 1'b1;
            foreach (m_hist[k]) if (m_hist[k][b] == m_level[b]) flip = 1'b0;
            if (flip) new_level[b] = ~m_level[b];
        end
        for (int b = 0; b < 6; b++) begin
            if (new_level[b] && !m_level[b]) begin
                m_hold[b] = 0;
                pulse[b]  = 1'b1;
            end else if (new_level[b]) begin
                m_hold[b]++;
                pulse[b] = REPEAT_MASK[b] && repeat_due(m_hold[b]);
            end
        end
        if (new_level[BTN_PIE_PLUS] && new_level[BTN_PIE_MINUS]) begin
            pulse[BTN_PIE_PLUS]  = 1'b0;
            pulse[BTN_PIE_MINUS] = 1'b0;
        end
        if (new_level[BTN_ST_PLUS] && new_level[BTN_ST_MINUS]) begin
            pulse[BTN_ST_PLUS]  = 1'b0;
            pulse[BTN_ST_MINUS] = 1'b0;
        end
        m_level = new_level;
    endtask

    // Starts just after a sampling edge; ends just after the next one.
    task automatic run_tick(input logic [5:0] raw_n);
        logic [5:0] exp_pulse, exp_level;
        bus.btn_raw_n = raw_n;
        tick_no++;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk_2M5);
            @(negedge clk_2M5);
            exp_pulse = '0;
            exp_level = m_level;
            if (c == 4) begin
                model_sample(~raw_n, exp_pulse);
                exp_level = m_level;
            end
            check("outputs{tick,level,pulse}",
                  {19'd0, bus.tick, bus.btn_level, bus.btn_pulse},
                  {19'd0, (c == 3), exp_level, exp_pulse});
            seg_pulses += $countones(bus.btn_pulse);
        end
    endtask

    task automatic run_seg(input string name, input logic [5:0] raw_n, input int n_ticks,
                           input logic [5:0] exp_level, input int exp_pulses);
        seg_pulses = 0;
        repeat (n_ticks) run_tick(raw_n);
        check({name, " level"}, {26'd0, bus.btn_level}, {26'd0, exp_level});
        check({name, " pulse count"}, seg_pulses, exp_pulses);
        $display("seg %-10s raw_n=%b ticks=%0d level=%b pulses=%0d", name, raw_n, n_ticks,
                 bus.btn_level, seg_pulses);
    endtask

    task automatic reset_cycles(input int n);
        reset_n = 1'b0;
        repeat (n) begin
            @(posedge clk_2M5);
            @(negedge clk_2M5);
            check("reset outputs", {19'd0, bus.tick, bus.btn_level, bus.btn_pulse}, 32'd0);
        end
        reset_n = 1'b1;
        model_reset();
        @(posedge clk_2M5);
        @(negedge clk_2M5);
        $display("reset for %0d cycles released", n);
    endtask

    initial begin
        logic [5:0] raw;

        table_v[0]  = '{6'b111011, 40, 6'b000100, 10};
        table_v[1]  = '{6'b111111,  5, 6'b000000,  1};
        table_v[2]  = '{6'b110111,  2, 6'b000000,  0};
        table_v[3]  = '{6'b111111,  3, 6'b000000,  0};
        table_v[4]  = '{6'b111110, 50, 6'b000001,  1};
        table_v[5]  = '{6'b111111,  4, 6'b000000,  0};
        table_v[6]  = '{6'b101011, 15, 6'b010100,  0};
        table_v[7]  = '{6'b111011, 12, 6'b000100,  2};
        table_v[8]  = '{6'b111111,  4, 6'b000000,  1};
        table_v[9]  = '{6'b111101, 20, 6'b000010,  1};
        table_v[10] = '{6'b111111,  4, 6'b000000,  0};

        bus.btn_raw_n = 6'b111111;
        reset_cycles(3);

        for (int i = 0; i < 11; i++)
            run_seg($sformatf("row%0d", i), table_v[i].raw_n, table_v[i].n_ticks,
                    table_v[i].exp_level, table_v[i].exp_pulses);

        // Reset while [5] is in fast repeat, then a fresh press with the button still held.
        run_seg("fast5", 6'b011111, 36, 6'b100000, 8);
        reset_cycles(3);
        run_seg("repress5a", 6'b011111, 2, 6'b000000, 0);
        run_seg("repress5b", 6'b011111, 1, 6'b100000, 1);
        run_seg("release5", 6'b111111, 4, 6'b000000, 0);

        raw = 6'b111111;
        for (int blk = 0; blk < 10; blk++) begin
            seg_pulses = 0;
            for (int t = 0; t < 50; t++) begin
                for (int b = 0; b < 6; b++)
                    if ($urandom_range(0, 9) == 0) raw[b] = ~raw[b];
                run_tick(raw);
            end
            $display("random block %0d: 50 ticks, last raw_n=%b, pulses=%0d", blk, raw, seg_pulses);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
